// File: rtl/print_channel_arbiter.sv
// Round-robin arbiter sharing one log channel; emits a banner record after reset.
// Define PRINT_ARB_FWRITE_EN to have the block write each accepted record itself.
module print_channel_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          MSG_W     = 8,
  parameter int          ARG_W     = 64,
  parameter logic [7:0]  CORE_ID   = 8'd0,
  parameter logic [39:0] COMMIT_ID = 40'h0,
  parameter logic        DIRTY     = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MSG_W-1:0]   req_msg,
  input  logic [NUM_REQ*ARG_W-1:0]   req_arg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_banner,
  output logic [MSG_W-1:0]           out_msg,
  output logic [ARG_W-1:0]           out_arg,
  output logic [31:0]                out_stamp,
  output logic                       banner_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [ARG_W-1:0] BANNER_ARG =
    ARG_W'({CORE_ID, DIRTY, 15'b0, COMMIT_ID});

  typedef enum logic [1:0] {
    S_BANNER = 2'd0,
    S_ARB    = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [31:0]   stamp_cnt;
  logic          found;
  logic [IW-1:0] win;
  int            idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_ARB && found) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_BANNER;
      ptr         <= '0;
      stamp_cnt   <= '0;
      out_valid   <= 1'b1;
      out_banner  <= 1'b1;
      out_src     <= '0;
      out_msg     <= '1;
      out_arg     <= BANNER_ARG;
      out_stamp   <= '0;
      banner_done <= 1'b0;
    end else begin
      stamp_cnt <= stamp_cnt + 32'd1;
      unique case (state)
        S_BANNER: begin
          if (out_ready) begin
            banner_done <= 1'b1;
            out_valid   <= 1'b0;
            state       <= S_ARB;
          end
        end
        S_ARB: begin
          if (found) begin
            out_valid  <= 1'b1;
            out_banner <= 1'b0;
            out_src    <= win;
            out_msg    <= req_msg[int'(win)*MSG_W +: MSG_W];
            out_arg    <= req_arg[int'(win)*ARG_W +: ARG_W];
            out_stamp  <= stamp_cnt;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_src == IW'(NUM_REQ - 1)) ptr <= '0;
            else                             ptr <= out_src + 1'b1;
            state <= S_ARB;
          end
        end
        default: state <= S_BANNER;
      endcase
    end
  end

`ifdef PRINT_ARB_FWRITE_EN
  always @(posedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (out_banner)
        $write(
          "Core %d's Commit SHA is: %h, dirty: %d\n",
          CORE_ID, COMMIT_ID, DIRTY);
      else
        $write(
          "[%0d] src %0d msg %h arg %h\n",
          out_stamp, out_src, out_msg, out_arg);
    end
  end
`else
`endif

endmodule

// File: tb/tb_print_channel_arbiter.sv
// Scoreboard bench for print_channel_arbiter: a cycle model predicts grants
// and records; directed phases check banner, order, backpressure and reset.
module tb_print_channel_arbiter;

  localparam logic [63:0] BANNER = 64'h0000_0068_b04f_5767;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [31:0]  req_msg;
  logic [255:0] req_arg;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_src;
  logic         out_banner;
  logic [7:0]   out_msg;
  logic [63:0]  out_arg;
  logic [31:0]  out_stamp;
  logic         banner_done;

  print_channel_arbiter #(
    .NUM_REQ(4), .MSG_W(8), .ARG_W(64),
    .CORE_ID(8'd0), .COMMIT_ID(40'h68b04f5767), .DIRTY(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .req_arg(req_arg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_banner(out_banner),
    .out_msg(out_msg), .out_arg(out_arg),
    .out_stamp(out_stamp), .banner_done(banner_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        banner;
    logic [1:0]  src;
    logic [7:0]  msg;
    logic [63:0] arg;
    logic [31:0] stamp;
  } rec_t;

  rec_t        q[$];
  logic [1:0]  served_src[$];
  logic [31:0] served_stamp[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          grant_cnt = 0;
  int          banner_seen = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model, advanced once per cycle at the falling edge
  typedef enum int { MB, MA, MS } mstate_t;
  mstate_t     m_state;
  logic [1:0]  m_ptr;
  logic [1:0]  m_win;
  logic [31:0] m_cnt;
  logic        m_bdone;

  function automatic rec_t banner_rec();
    rec_t r;
    r.banner = 1'b1;
    r.src    = 2'd0;
    r.msg    = 8'hff;
    r.arg    = BANNER;
    r.stamp  = 32'd0;
    return r;
  endfunction

  always @(negedge clock) begin
    logic [3:0] exp_rdy;
    logic       f;
    logic [1:0] w;
    rec_t       r;
    if (!reset_n) begin
      m_state = MB;
      m_ptr   = 2'd0;
      m_cnt   = 32'd0;
      m_bdone = 1'b0;
      q.delete();
      q.push_back(banner_rec());
    end else begin
      exp_rdy = 4'b0;
      f = 1'b0;
      w = 2'd0;
      if (m_state == MA) begin
        for (int k = 0; k < 4; k++) begin
          logic [1:0] j;
          j = m_ptr + 2'(k);
          if (!f && req_valid[j]) begin
            f = 1'b1;
            w = j;
          end
        end
        if (f) exp_rdy[w] = 1'b1;
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(m_state != MA));
      check("banner_done", 64'(banner_done), 64'(m_bdone));
      if (|req_ready) grant_cnt++;
      if (m_state != MA) begin
        if (q.size() == 0) begin
          check("sb_depth", 64'(q.size()), 64'd1);
        end else begin
          r = q[0];
          check("out_banner", 64'(out_banner), 64'(r.banner));
          check("out_src", 64'(out_src), 64'(r.src));
          check("out_msg", 64'(out_msg), 64'(r.msg));
          check("out_arg", out_arg, r.arg);
          check("out_stamp", 64'(out_stamp), 64'(r.stamp));
          if (out_ready) begin
            void'(q.pop_front());
            if (r.banner) banner_seen++;
            else begin
              served_src.push_back(r.src);
              served_stamp.push_back(r.stamp);
            end
          end
        end
      end
      case (m_state)
        MB: if (out_ready) begin
          m_bdone = 1'b1;
          m_state = MA;
        end
        MA: if (f) begin
          r.banner = 1'b0;
          r.src    = w;
          r.msg    = req_msg[int'(w)*8 +: 8];
          r.arg    = req_arg[int'(w)*64 +: 64];
          r.stamp  = m_cnt;
          q.push_back(r);
          m_win   = w;
          m_state = MS;
        end
        default: if (out_ready) begin
          m_ptr   = m_win + 2'd1;
          m_state = MA;
        end
      endcase
      m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic fill_payload();
    for (int i = 0; i < 4; i++) begin
      req_msg[i*8 +: 8]   = 8'($urandom);
      req_arg[i*64 +: 64] = {$urandom, $urandom};
    end
  endtask

  initial begin
    int gc0;
    int bs0;
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b0;
    req_msg   = '0;
    req_arg   = '0;
    fill_payload();
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd1);
    check("rst_out_banner", 64'(out_banner), 64'd1);
    check("rst_out_msg", 64'(out_msg), 64'hff);
    check("rst_out_stamp", 64'(out_stamp), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_banner_done", 64'(banner_done), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    step(1);
    reset_n = 1'b1;

    // banner held off by the sink while everyone requests
    step(10);
    check("hold_arg", out_arg, BANNER);
    check("hold_grants", 64'(grant_cnt), 64'd0);

    // round robin with a free-flowing sink
    served_src.delete();
    served_stamp.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && served_src.size() < 5; i++) begin
      fill_payload();
      step(1);
    end
    check("rr_count", 64'(served_src.size() >= 5), 64'd1);
    check("banner_done_set", 64'(banner_done), 64'd1);
    if (served_src.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        check("rr_order", 64'(served_src[i]), 64'(i % 4));
      for (int i = 1; i < 5; i++)
        check("rr_stamp_gap",
              64'(served_stamp[i] - served_stamp[i-1]), 64'd2);
    end
    req_valid = 4'b0000;
    step(4);

    // sink backpressure on a lone requester
    served_src.delete();
    gc0 = grant_cnt;
    req_valid = 4'b0100;
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step(1);
    check("bp_valid", 64'(out_valid), 64'd1);
    step(5);
    check("bp_grants", 64'(grant_cnt - gc0), 64'd1);
    check("bp_pending", 64'(served_src.size()), 64'd0);
    out_ready = 1'b1;
    req_valid = 4'b0000;
    step(1);
    check("bp_done", 64'(served_src.size()), 64'd1);
    if (served_src.size() == 1)
      check("bp_src", 64'(served_src[0]), 64'd2);
    step(2);

    // pointer advance: grant 3, then 0 and 3 both pending
    served_src.delete();
    req_valid = 4'b1000;
    for (int i = 0; i < 10 && served_src.size() < 1; i++) step(1);
    req_valid = 4'b1001;
    for (int i = 0; i < 20 && served_src.size() < 3; i++) step(1);
    check("ptr_count", 64'(served_src.size() >= 3), 64'd1);
    if (served_src.size() >= 3) begin
      check("ptr_first", 64'(served_src[0]), 64'd3);
      check("ptr_next0", 64'(served_src[1]), 64'd0);
      check("ptr_next3", 64'(served_src[2]), 64'd3);
    end
    req_valid = 4'b0000;
    step(4);

    // reset in the middle of a send
    req_valid = 4'b0100;
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !(out_valid && !out_banner); i++) step(1);
    check("mid_in_send", 64'(out_valid && !out_banner), 64'd1);
    bs0 = banner_seen;
    reset_n = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd1);
    check("mid_out_banner", 64'(out_banner), 64'd1);
    check("mid_banner_done", 64'(banner_done), 64'd0);
    check("mid_out_arg", out_arg, BANNER);
    req_valid = 4'b0000;
    step(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && !banner_done; i++) step(1);
    check("mid_replay", 64'(banner_seen - bs0), 64'd1);
    check("mid_done_again", 64'(banner_done), 64'd1);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
